// File: rtl/instr_encoder_pkg.sv
// Shared RV32I types for the instruction encoder: operation IDs, major opcodes,
// instruction formats and an immediate range helper.
package instr_encoder_pkg;

    typedef enum logic [5:0] {
        PID_LUI, PID_AUIPC, PID_JAL, PID_JALR,
        PID_BEQ, PID_BNE, PID_BLT, PID_BGE, PID_BLTU, PID_BGEU,
        PID_LB, PID_LH, PID_LW, PID_LBU, PID_LHU,
        PID_SB, PID_SH, PID_SW,
        PID_ADDI, PID_SLTI, PID_SLTIU, PID_XORI, PID_ORI, PID_ANDI,
        PID_SLLI, PID_SRLI, PID_SRAI,
        PID_ADD, PID_SUB, PID_SLL, PID_SLT, PID_SLTU,
        PID_XOR, PID_SRL, PID_SRA, PID_OR, PID_AND,
        PID_ECALL, PID_EBREAK,
        PID_UNKNOWN
    } pid_t;

    typedef enum logic [2:0] {R, I, S, B, U, J, SYS} instr_format_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // True when value is the sign extension of its low 'width' bits.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned width);
        logic [31:0] upper_mask;
        upper_mask = 32'hFFFF_FFFF << (width - 1);
        return ((value & upper_mask) == 32'h0) || ((value & upper_mask) == upper_mask);
    endfunction

endpackage

// File: rtl/instr_encoder_encode_fields.sv
// Combinational RV32I field packer: maps an operation and its decoded fields to
// the canonical instruction word, flagging field sets no encoding can represent.
module encode_fields
    import instr_encoder_pkg::*;
(
    input  pid_t        pid,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        illegal
);

    instr_format_t fmt;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          alt;
    logic          shift;
    logic          known;

    always_comb begin
        fmt    = SYS;
        opcode = OPC_SYSTEM;
        funct3 = 3'd0;
        alt    = 1'b0;
        shift  = 1'b0;
        known  = 1'b1;
        case (pid)
            PID_LUI:    begin fmt = U; opcode = OPC_LUI;   end
            PID_AUIPC:  begin fmt = U; opcode = OPC_AUIPC; end
            PID_JAL:    begin fmt = J; opcode = OPC_JAL;   end
            PID_JALR:   begin fmt = I; opcode = OPC_JALR;  end
            PID_BEQ:    begin fmt = B; opcode = OPC_BRANCH; funct3 = 3'd0; end
            PID_BNE:    begin fmt = B; opcode = OPC_BRANCH; funct3 = 3'd1; end
            PID_BLT:    begin fmt = B; opcode = OPC_BRANCH; funct3 = 3'd4; end
            PID_BGE:    begin fmt = B; opcode = OPC_BRANCH; funct3 = 3'd5; end
            PID_BLTU:   begin fmt = B; opcode = OPC_BRANCH; funct3 = 3'd6; end
            PID_BGEU:   begin fmt = B; opcode = OPC_BRANCH; funct3 = 3'd7; end
            PID_LB:     begin fmt = I; opcode = OPC_LOAD;   funct3 = 3'd0; end
            PID_LH:     begin fmt = I; opcode = OPC_LOAD;   funct3 = 3'd1; end
            PID_LW:     begin fmt = I; opcode = OPC_LOAD;   funct3 = 3'd2; end
            PID_LBU:    begin fmt = I; opcode = OPC_LOAD;   funct3 = 3'd4; end
            PID_LHU:    begin fmt = I; opcode = OPC_LOAD;   funct3 = 3'd5; end
            PID_SB:     begin fmt = S; opcode = OPC_STORE;  funct3 = 3'd0; end
            PID_SH:     begin fmt = S; opcode = OPC_STORE;  funct3 = 3'd1; end
            PID_SW:     begin fmt = S; opcode = OPC_STORE;  funct3 = 3'd2; end
            PID_ADDI:   begin fmt = I; opcode = OPC_OPIMM;  funct3 = 3'd0; end
            PID_SLTI:   begin fmt = I; opcode = OPC_OPIMM;  funct3 = 3'd2; end
            PID_SLTIU:  begin fmt = I; opcode = OPC_OPIMM;  funct3 = 3'd3; end
            PID_XORI:   begin fmt = I; opcode = OPC_OPIMM;  funct3 = 3'd4; end
            PID_ORI:    begin fmt = I; opcode = OPC_OPIMM;  funct3 = 3'd6; end
            PID_ANDI:   begin fmt = I; opcode = OPC_OPIMM;  funct3 = 3'd7; end
            PID_SLLI:   begin fmt = I; opcode = OPC_OPIMM;  funct3 = 3'd1; shift = 1'b1; end
            PID_SRLI:   begin fmt = I; opcode = OPC_OPIMM;  funct3 = 3'd5; shift = 1'b1; end
            PID_SRAI:   begin fmt = I; opcode = OPC_OPIMM;  funct3 = 3'd5; shift = 1'b1; alt = 1'b1; end
            PID_ADD:    begin fmt = R; opcode = OPC_OP;     funct3 = 3'd0; end
            PID_SUB:    begin fmt = R; opcode = OPC_OP;     funct3 = 3'd0; alt = 1'b1; end
            PID_SLL:    begin fmt = R; opcode = OPC_OP;     funct3 = 3'd1; end
            PID_SLT:    begin fmt = R; opcode = OPC_OP;     funct3 = 3'd2; end
            PID_SLTU:   begin fmt = R; opcode = OPC_OP;     funct3 = 3'd3; end
            PID_XOR:    begin fmt = R; opcode = OPC_OP;     funct3 = 3'd4; end
            PID_SRL:    begin fmt = R; opcode = OPC_OP;     funct3 = 3'd5; end
            PID_SRA:    begin fmt = R; opcode = OPC_OP;     funct3 = 3'd5; alt = 1'b1; end
            PID_OR:     begin fmt = R; opcode = OPC_OP;     funct3 = 3'd6; end
            PID_AND:    begin fmt = R; opcode = OPC_OP;     funct3 = 3'd7; end
            PID_ECALL:  begin fmt = SYS; end
            PID_EBREAK: begin fmt = SYS; alt = 1'b1; end
            default:    known = 1'b0;
        endcase
    end

    // Shift immediates carry only a 5-bit shamt, with bit 30 selecting arithmetic.
    always_comb begin
        instr   = 32'h0;
        illegal = 1'b0;
        if (!known) begin
            illegal = 1'b1;
        end else begin
            case (fmt)
                R: instr = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, opcode};
                I: begin
                    if (shift) begin
                        illegal = |imm[31:5];
                        instr   = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, opcode};
                    end else begin
                        illegal = !fits_signed(imm, 12);
                        instr   = {imm[11:0], rs1, funct3, rd, opcode};
                    end
                end
                S: begin
                    illegal = !fits_signed(imm, 12);
                    instr   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                end
                B: begin
                    illegal = !fits_signed(imm, 13) || imm[0];
                    instr   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                end
                U: begin
                    illegal = |imm[11:0];
                    instr   = {imm[31:12], rd, opcode};
                end
                J: begin
                    illegal = !fits_signed(imm, 21) || imm[0];
                    instr   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                end
                SYS:     instr = {11'b0, alt, 13'b0, opcode};
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: valid/ready field sets in, encoded words with their
// instruction-memory addresses out, plus sticky error tracking for illegal sets.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  pid_t                  pid,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    input  logic                  restart,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  error,
    output logic [7:0]            err_count
);

    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR_W = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(4);

    logic [31:0] enc_instr;
    logic        enc_illegal;
    logic        in_fire;
    logic        out_fire;

    encode_fields u_encode_fields (
        .pid     (pid),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .imm     (imm),
        .instr   (enc_instr),
        .illegal (enc_illegal)
    );

    assign in_ready = !restart && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready && !restart;

    // out_addr always names the next word to be emitted, so a word loaded on the
    // same edge as a handshake picks up the advanced address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_addr  <= BASE_ADDR_W;
            error     <= 1'b0;
            err_count <= 8'h0;
        end else if (restart) begin
            out_valid <= 1'b0;
            out_addr  <= BASE_ADDR_W;
            error     <= 1'b0;
            err_count <= 8'h0;
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
                out_addr  <= out_addr + ADDR_STEP;
            end
            if (in_fire) begin
                if (enc_illegal) begin
                    error <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'h1;
                    end
                end else begin
                    out_valid <= 1'b1;
                    out_instr <= enc_instr;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed RV32I cases with literal words,
// then randomized traffic against a transaction-level reference model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, restart, out_ready;
    pid_t        pid;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        in_ready, out_valid, error;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_count;
    logic        small_in_ready, small_out_valid, small_error;
    logic [31:0] small_out_instr;
    logic [3:0]  small_out_addr;
    logic [7:0]  small_err_count;

    int n_checks = 0;
    int n_fails  = 0;
    int cycle    = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        logic [3:0]  saddr;
        int          cyc;
    } seen_t;

    seen_t       seen_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_addr;
    bit          m_err;
    int          m_cnt;

    instr_encoder #(.BASE_ADDR(BASE), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .pid(pid), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .restart(restart),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .error(error), .err_count(err_count)
    );

    instr_encoder #(.BASE_ADDR(BASE), .ADDR_WIDTH(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(small_in_ready),
        .pid(pid), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .restart(restart),
        .out_valid(small_out_valid), .out_ready(out_ready), .out_instr(small_out_instr),
        .out_addr(small_out_addr), .error(small_error), .err_count(small_err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference encoder built from the RV32I format tables with plain arithmetic.
    function automatic void model_encode(input pid_t p, input logic [4:0] d, input logic [4:0] a,
                                         input logic [4:0] b, input logic [31:0] im,
                                         output bit ok, output logic [31:0] w);
        byte         fmt;
        logic [31:0] opc, f3, alt, dd, aa, bb;
        int          sv;
        fmt = "X"; opc = 0; f3 = 0; alt = 0;
        dd = 32'(d); aa = 32'(a); bb = 32'(b);
        sv = im;
        case (p)
            PID_LUI:   begin fmt = "U"; opc = 'h37; end
            PID_AUIPC: begin fmt = "U"; opc = 'h17; end
            PID_JAL:   begin fmt = "J"; opc = 'h6f; end
            PID_JALR:  begin fmt = "I"; opc = 'h67; end
            PID_BEQ:   begin fmt = "B"; opc = 'h63; f3 = 0; end
            PID_BNE:   begin fmt = "B"; opc = 'h63; f3 = 1; end
            PID_BLT:   begin fmt = "B"; opc = 'h63; f3 = 4; end
            PID_BGE:   begin fmt = "B"; opc = 'h63; f3 = 5; end
            PID_BLTU:  begin fmt = "B"; opc = 'h63; f3 = 6; end
            PID_BGEU:  begin fmt = "B"; opc = 'h63; f3 = 7; end
            PID_LB:    begin fmt = "I"; opc = 'h03; f3 = 0; end
            PID_LH:    begin fmt = "I"; opc = 'h03; f3 = 1; end
            PID_LW:    begin fmt = "I"; opc = 'h03; f3 = 2; end
            PID_LBU:   begin fmt = "I"; opc = 'h03; f3 = 4; end
            PID_LHU:   begin fmt = "I"; opc = 'h03; f3 = 5; end
            PID_SB:    begin fmt = "S"; opc = 'h23; f3 = 0; end
            PID_SH:    begin fmt = "S"; opc = 'h23; f3 = 1; end
            PID_SW:    begin fmt = "S"; opc = 'h23; f3 = 2; end
            PID_ADDI:  begin fmt = "I"; opc = 'h13; f3 = 0; end
            PID_SLTI:  begin fmt = "I"; opc = 'h13; f3 = 2; end
            PID_SLTIU: begin fmt = "I"; opc = 'h13; f3 = 3; end
            PID_XORI:  begin fmt = "I"; opc = 'h13; f3 = 4; end
            PID_ORI:   begin fmt = "I"; opc = 'h13; f3 = 6; end
            PID_ANDI:  begin fmt = "I"; opc = 'h13; f3 = 7; end
            PID_SLLI:  begin fmt = "H"; opc = 'h13; f3 = 1; end
            PID_SRLI:  begin fmt = "H"; opc = 'h13; f3 = 5; end
            PID_SRAI:  begin fmt = "H"; opc = 'h13; f3 = 5; alt = 1; end
            PID_ADD:   begin fmt = "R"; opc = 'h33; f3 = 0; end
            PID_SUB:   begin fmt = "R"; opc = 'h33; f3 = 0; alt = 1; end
            PID_SLL:   begin fmt = "R"; opc = 'h33; f3 = 1; end
            PID_SLT:   begin fmt = "R"; opc = 'h33; f3 = 2; end
            PID_SLTU:  begin fmt = "R"; opc = 'h33; f3 = 3; end
            PID_XOR:   begin fmt = "R"; opc = 'h33; f3 = 4; end
            PID_SRL:   begin fmt = "R"; opc = 'h33; f3 = 5; end
            PID_SRA:   begin fmt = "R"; opc = 'h33; f3 = 5; alt = 1; end
            PID_OR:    begin fmt = "R"; opc = 'h33; f3 = 6; end
            PID_AND:   begin fmt = "R"; opc = 'h33; f3 = 7; end
            PID_ECALL: begin fmt = "E"; opc = 'h73; end
            PID_EBREAK:begin fmt = "E"; opc = 'h73; alt = 1; end
            default:   fmt = "X";
        endcase
        ok = 1'b1;
        w  = 32'h0;
        case (fmt)
            "I": begin
                ok = (sv >= -2048) && (sv <= 2047);
                w  = ((im & 'hfff) << 20) | (aa << 15) | (f3 << 12) | (dd << 7) | opc;
            end
            "H": begin
                ok = (im < 32);
                w  = (alt << 30) | (im << 20) | (aa << 15) | (f3 << 12) | (dd << 7) | opc;
            end
            "S": begin
                ok = (sv >= -2048) && (sv <= 2047);
                w  = (((im >> 5) & 'h7f) << 25) | (bb << 20) | (aa << 15) | (f3 << 12)
                   | ((im & 'h1f) << 7) | opc;
            end
            "B": begin
                ok = (sv >= -4096) && (sv <= 4095) && (im % 2 == 0);
                w  = (((im >> 12) & 1) << 31) | (((im >> 5) & 'h3f) << 25) | (bb << 20)
                   | (aa << 15) | (f3 << 12) | (((im >> 1) & 'hf) << 8)
                   | (((im >> 11) & 1) << 7) | opc;
            end
            "U": begin
                ok = (im % 4096 == 0);
                w  = im | (dd << 7) | opc;
            end
            "J": begin
                ok = (sv >= -1048576) && (sv <= 1048575) && (im % 2 == 0);
                w  = (((im >> 20) & 1) << 31) | (((im >> 1) & 'h3ff) << 21)
                   | (((im >> 11) & 1) << 20) | (((im >> 12) & 'hff) << 12) | (dd << 7) | opc;
            end
            "R": w = (alt << 30) | (bb << 20) | (aa << 15) | (f3 << 12) | (dd << 7) | opc;
            "E": w = (alt << 20) | opc;
            default: ok = 1'b0;
        endcase
    endfunction

    // Per-cycle compare against the model, then advance the model for the next edge.
    always @(negedge clk) begin
        bit          exp_valid, exp_ready, ok;
        logic [31:0] w;
        cycle++;
        if (!reset_n) begin
            exp_q.delete();
            m_addr = BASE;
            m_err  = 1'b0;
            m_cnt  = 0;
            checkOutput("reset out_valid", 32'(out_valid), 32'h0);
            checkOutput("reset out_instr", out_instr, 32'h0);
            checkOutput("reset out_addr", out_addr, BASE);
            checkOutput("reset error", 32'(error), 32'h0);
            checkOutput("reset err_count", 32'(err_count), 32'h0);
        end else begin
            exp_valid = (exp_q.size() != 0);
            exp_ready = !restart && (!exp_valid || out_ready);
            checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
            checkOutput("small out_valid", 32'(small_out_valid), 32'(exp_valid));
            checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
            checkOutput("small in_ready", 32'(small_in_ready), 32'(exp_ready));
            checkOutput("out_addr", out_addr, m_addr);
            checkOutput("small out_addr", 32'(small_out_addr), m_addr & 32'hF);
            checkOutput("error", 32'(error), 32'(m_err));
            checkOutput("err_count", 32'(err_count), 32'(m_cnt));
            checkOutput("small err_count", 32'(small_err_count), 32'(m_cnt));
            if (exp_valid) begin
                checkOutput("out_instr", out_instr, exp_q[0]);
                checkOutput("small out_instr", small_out_instr, exp_q[0]);
            end
            if (out_valid && out_ready && !restart)
                seen_q.push_back('{word: out_instr, addr: out_addr, saddr: small_out_addr, cyc: cycle});
            if (restart) begin
                exp_q.delete();
                m_addr = BASE;
                m_err  = 1'b0;
                m_cnt  = 0;
            end else begin
                if (exp_valid && out_ready) begin
                    void'(exp_q.pop_front());
                    m_addr = m_addr + 4;
                end
                if (in_valid && exp_ready) begin
                    model_encode(pid, rd, rs1, rs2, imm, ok, w);
                    if (ok) exp_q.push_back(w);
                    else begin
                        m_err = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doRestart();
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
    endtask

    task automatic applyStimulus(input pid_t p, input logic [4:0] d, input logic [4:0] a,
                                 input logic [4:0] b, input logic [31:0] im);
        int waited = 0;
        bit done   = 1'b0;
        in_valid = 1'b1; pid = p; rd = d; rs1 = a; rs2 = b; imm = im;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else if (waited++ >= 20) begin
                n_checks++; n_fails++;
                $display("[TB] FAIL accept %s: got no in_ready, expected accept within 20 cycles", p.name());
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic checkSeen(input int idx, input logic [31:0] word, input logic [31:0] addr);
        if (idx < seen_q.size()) begin
            checkOutput($sformatf("word[%0d]", idx), seen_q[idx].word, word);
            checkOutput($sformatf("addr[%0d]", idx), seen_q[idx].addr, addr);
        end else begin
            n_checks++; n_fails++;
            $display("[TB] FAIL word[%0d]: got no output word, expected 0x%08h", idx, word);
        end
    endtask

    function automatic logic [31:0] gen_imm();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 5))
            0:       return r;
            1:       return {{20{r[11]}}, r[11:0]};
            2:       return {{19{r[12]}}, r[12:1], 1'b0};
            3:       return {{11{r[20]}}, r[20:1], 1'b0};
            4:       return {r[31:12], 12'b0};
            default: return {27'b0, r[4:0]};
        endcase
    endfunction

    initial begin
        reset_n = 1'b1; in_valid = 1'b0; restart = 1'b0; out_ready = 1'b1;
        pid = PID_ADDI; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'h0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        $display("[TB] back-to-back ADDI / ADD");
        seen_q.delete();
        applyStimulus(PID_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        applyStimulus(PID_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        waitCycles(3);
        checkSeen(0, 32'h0050_0093, 32'h0);
        checkSeen(1, 32'h0020_81B3, 32'h4);
        if (seen_q.size() >= 2) checkOutput("no bubble", 32'(seen_q[1].cyc - seen_q[0].cyc), 32'd1);

        $display("[TB] SUB / BEQ / SW");
        doRestart();
        seen_q.delete();
        applyStimulus(PID_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        applyStimulus(PID_BEQ, 5'd0, 5'd1, 5'd2, 32'd8);
        applyStimulus(PID_SW, 5'd0, 5'd1, 5'd2, 32'd12);
        waitCycles(3);
        checkSeen(0, 32'h4020_81B3, 32'h0);
        checkSeen(1, 32'h0020_8463, 32'h4);
        checkSeen(2, 32'h0020_A623, 32'h8);

        $display("[TB] LUI / JAL / illegal LUI");
        doRestart();
        seen_q.delete();
        applyStimulus(PID_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        applyStimulus(PID_JAL, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        applyStimulus(PID_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5001);
        waitCycles(3);
        checkSeen(0, 32'h1234_52B7, 32'h0);
        checkSeen(1, 32'h0010_00EF, 32'h4);
        @(negedge clk);
        checkOutput("illegal no word", 32'(seen_q.size()), 32'd2);
        checkOutput("illegal out_valid", 32'(out_valid), 32'h0);
        checkOutput("illegal addr held", out_addr, 32'h8);
        checkOutput("illegal error", 32'(error), 32'h1);
        checkOutput("illegal err_count", 32'(err_count), 32'h1);
        @(posedge clk); #1;

        $display("[TB] stall with out_ready low");
        out_ready = 1'b0;
        in_valid = 1'b1; pid = PID_ADDI; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd5;
        @(posedge clk); #1;
        pid = PID_ADD; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall in_ready", 32'(in_ready), 32'h0);
            checkOutput("stall out_instr", out_instr, 32'h0050_0093);
            checkOutput("stall out_addr", out_addr, 32'h8);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("release out_valid", 32'(out_valid), 32'h1);
        checkOutput("release out_instr", out_instr, 32'h0020_81B3);
        checkOutput("release out_addr", out_addr, 32'hC);
        @(posedge clk); #1;

        $display("[TB] restart against handshakes");
        restart = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; pid = PID_SUB; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 32'd0;
        @(negedge clk);
        checkOutput("restart in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        restart = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("restart out_valid", 32'(out_valid), 32'h0);
        checkOutput("restart out_addr", out_addr, 32'h0);
        checkOutput("restart error", 32'(error), 32'h0);
        checkOutput("restart err_count", 32'(err_count), 32'h0);
        @(posedge clk); #1;

        $display("[TB] 4-bit address wrap and mid-stream reset");
        seen_q.delete();
        for (int k = 0; k < 5; k++)
            applyStimulus(PID_ADDI, 5'(k), 5'd0, 5'd0, 32'(k));
        waitCycles(2);
        checkOutput("wrap count", 32'(seen_q.size()), 32'd5);
        if (seen_q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                checkOutput($sformatf("wrap small addr[%0d]", k), 32'(seen_q[k].saddr), 32'((4 * k) % 16));
                checkOutput($sformatf("wrap addr[%0d]", k), seen_q[k].addr, 32'(4 * k));
            end
        end
        applyStimulus(PID_UNKNOWN, 5'd0, 5'd0, 5'd0, 32'd0);
        out_ready = 1'b0;
        applyStimulus(PID_ORI, 5'd7, 5'd6, 5'd0, 32'hFFFF_FFFF);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("async reset out_instr", out_instr, 32'h0);
        checkOutput("async reset out_addr", out_addr, 32'h0);
        checkOutput("async reset small addr", 32'(small_out_addr), 32'h0);
        checkOutput("async reset error", 32'(error), 32'h0);
        checkOutput("async reset err_count", 32'(err_count), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1; out_ready = 1'b1;
        waitCycles(1);

        $display("[TB] err_count saturation");
        in_valid = 1'b1; pid = PID_UNKNOWN;
        repeat (260) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("err_count saturated", 32'(err_count), 32'd255);
        @(posedge clk); #1;

        $display("[TB] randomized traffic");
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            restart   = ($urandom_range(0, 63) == 0);
            pid       = pid_t'($urandom_range(0, 39));
            rd        = 5'($urandom());
            rs1       = 5'($urandom());
            rs2       = 5'($urandom());
            imm       = gen_imm();
            @(posedge clk); #1;
        end
        in_valid = 1'b0; restart = 1'b0; out_ready = 1'b1;
        waitCycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
